// File: rtl/semaforo_pkg.sv
// -----------------------------------------------------------------------------
// semaforo_pkg
// Shared types and constants for the local intersection phase sequencer:
//   - state_e   : sequencer states
//   - appr_t    : 2-bit approach index (approaches 0..3)
//   - CODE_*    : cycle codes understood by the traffic-light decoder
//   - MODE_*    : encodings of the mode output
//   - pick_lowest(): lowest unskipped approach at or above a given index
// -----------------------------------------------------------------------------
package semaforo_pkg;

    typedef enum logic [2:0] {
        ST_GREEN,
        ST_GBLINK,
        ST_YELLOW,
        ST_CLEAR,
        ST_NIGHT,
        ST_EMERG
    } state_e;

    typedef logic [1:0] appr_t;

    localparam logic [4:0] CODE_CLEAR = 5'd7;
    localparam logic [4:0] CODE_NIGHT = 5'd8;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_NIGHT  = 2'b01;
    localparam logic [1:0] MODE_EMERG  = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    typedef struct packed {
        logic  found;
        appr_t idx;
    } pick_t;

    // Lowest approach i with i >= lo and skip[i]==0. lo may be 4 (nothing left).
    function automatic pick_t pick_lowest(input logic [3:0] skip, input logic [2:0] lo);
        pick_t r;
        r.found = 1'b0;
        r.idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(lo) && !skip[i]) begin
                r.found = 1'b1;
                r.idx   = appr_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/semaforo_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle pulse every CLK_DIV clocks.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-low reset (count returns to 0)
//   tick_o out high while the count equals CLK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_DIV = 27_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/semaforo_sequencer.sv
// -----------------------------------------------------------------------------
// semaforo_sequencer
// Local phase sequencer for a 4-approach intersection. Rotates green ->
// blinking green -> yellow through unskipped approaches, with all-red
// clearance, flashing-yellow night mode and all-red emergency hold.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-low reset
//   night  in   night-mode request (level)
//   emerg  in   emergency request (level, highest priority)
//   skip   in   skip[a]=1 removes approach a from rotation
//   ciclo  out  5-bit cycle code for the decoder
//   dest   out  blink enable for the decoder
//   tick   out  one-cycle prescaler pulse
//   mode   out  00 normal, 01 night, 10 emergency, 11 clearing
// -----------------------------------------------------------------------------
module semaforo_sequencer
    import semaforo_pkg::*;
#(
    parameter int CLK_DIV  = 27_000_000,
    parameter int T_GREEN  = 20,
    parameter int T_BLINK  = 3,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int TW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night,
    input  logic       emerg,
    input  logic [3:0] skip,
    output logic [4:0] ciclo,
    output logic       dest,
    output logic       tick,
    output logic [1:0] mode
);

    state_e        state_q, state_d;
    appr_t         appr_q, appr_d;
    logic [TW-1:0] rem_q, rem_d;
    logic          pend_q, pend_d;   // mode request seen before/during yellow

    logic  req, expire;
    pick_t nxt, first;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    assign req    = emerg | night;
    assign expire = tick && (rem_q == TW'(1));
    assign nxt    = pick_lowest(skip, {1'b0, appr_q} + 3'd1);
    assign first  = pick_lowest(skip, 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            appr_q  <= '0;
            rem_q   <= TW'(T_ALLRED);
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            appr_q  <= appr_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        appr_d  = appr_q;
        rem_d   = rem_q;
        pend_d  = 1'b0;
        case (state_q)
            ST_GREEN, ST_GBLINK: begin
                // A mode request cuts the green short; approach 3 has no yellow.
                if (req || (expire && state_q == ST_GBLINK)) begin
                    if (appr_q != 2'd3) begin
                        state_d = ST_YELLOW;
                        rem_d   = TW'(T_YELLOW);
                        pend_d  = req;
                    end else begin
                        state_d = ST_CLEAR;
                        rem_d   = TW'(T_ALLRED);
                    end
                end else if (expire) begin
                    state_d = ST_GBLINK;
                    rem_d   = TW'(T_BLINK);
                end else if (tick) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_YELLOW: begin
                pend_d = pend_q | req;
                if (expire) begin
                    pend_d = 1'b0;
                    if (pend_q || req || !nxt.found) begin
                        state_d = ST_CLEAR;
                        rem_d   = TW'(T_ALLRED);
                    end else begin
                        state_d = ST_GREEN;
                        appr_d  = nxt.idx;
                        rem_d   = TW'(T_GREEN);
                    end
                end else if (tick) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_CLEAR: begin
                if (expire) begin
                    if (emerg) begin
                        state_d = ST_EMERG;
                    end else if (night) begin
                        state_d = ST_NIGHT;
                    end else if (first.found) begin
                        state_d = ST_GREEN;
                        appr_d  = first.idx;
                        rem_d   = TW'(T_GREEN);
                    end else begin
                        rem_d = TW'(T_ALLRED);   // everything skipped: hold all-red
                    end
                end else if (tick) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_NIGHT: begin
                if (emerg) begin
                    state_d = ST_EMERG;
                end else if (!night) begin
                    state_d = ST_CLEAR;
                    rem_d   = TW'(T_ALLRED);
                end
            end
            ST_EMERG: begin
                if (!emerg) begin
                    state_d = ST_CLEAR;
                    rem_d   = TW'(T_ALLRED);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                rem_d   = TW'(T_ALLRED);
            end
        endcase
    end

    always_comb begin
        ciclo = CODE_CLEAR;
        dest  = 1'b0;
        mode  = MODE_CLEAR;
        case (state_q)
            ST_GREEN:  begin ciclo = {2'b00, appr_q, 1'b0}; mode = MODE_NORMAL; end
            ST_GBLINK: begin ciclo = {2'b00, appr_q, 1'b0}; dest = 1'b1; mode = MODE_NORMAL; end
            ST_YELLOW: begin ciclo = {2'b00, appr_q, 1'b1}; mode = MODE_NORMAL; end
            ST_NIGHT:  begin ciclo = CODE_NIGHT; dest = 1'b1; mode = MODE_NIGHT; end
            ST_EMERG:  begin mode = MODE_EMERG; end
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_semaforo_sequencer.sv
module tb_semaforo_sequencer;

    typedef struct {
        logic [4:0] ciclo;
        logic       dest;
        logic [1:0] mode;
        int         dur;    // cycles the previous output was held; 0 = unchecked
    } exp_t;

    logic       clk = 1'b0, rst = 1'b0, night = 1'b0, emerg = 1'b0;
    logic [3:0] skip = 4'd0;
    logic [4:0] ciclo;
    logic       dest, tick;
    logic [1:0] mode;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, n_evt = 0;

    semaforo_sequencer #(
        .CLK_DIV(4), .T_GREEN(4), .T_BLINK(2), .T_YELLOW(2), .T_ALLRED(1), .TW(8)
    ) dut (
        .clk(clk), .rst(rst), .night(night), .emerg(emerg), .skip(skip),
        .ciclo(ciclo), .dest(dest), .tick(tick), .mode(mode)
    );

    always #5 clk = ~clk;

    // reset value the DUT saw at the latest edge
    logic rst_s = 1'b1;
    always @(posedge clk) rst_s <= rst;

    task automatic ex(input logic [4:0] c, input logic d, input logic [1:0] m, input int dur);
        exp_t e;
        e.ciclo = c; e.dest = d; e.mode = m; e.dur = dur;
        q.push_back(e);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Two reset edges; the second is edge 0 of the following scenario.
    task automatic do_reset(input logic [3:0] sk);
        rst = 1'b0; night = 1'b0; emerg = 1'b0; skip = sk;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Monitor: every output change pops one expected entry.
    logic       started = 1'b0;
    logic [7:0] prev, cur;
    int         held, tcnt;
    exp_t       e;
    always @(negedge clk) begin
        cur = {ciclo, dest, mode};
        if (!started) begin
            if (!rst_s) begin
                started = 1'b1; prev = cur; held = 1; tcnt = 1;
            end
        end else begin
            if (cur !== prev) begin
                n_evt++;
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL change[%0d]: got ciclo=%0d dest=%0b mode=%b, expected no change",
                             n_evt, ciclo, dest, mode);
                end else begin
                    e = q.pop_front();
                    if (cur !== {e.ciclo, e.dest, e.mode}) begin
                        n_fail++;
                        $display("FAIL out[%0d]: got ciclo=%0d dest=%0b mode=%b, expected ciclo=%0d dest=%0b mode=%b",
                                 n_evt, ciclo, dest, mode, e.ciclo, e.dest, e.mode);
                    end
                    if (e.dur != 0) begin
                        n_chk++;
                        if (held != e.dur) begin
                            n_fail++;
                            $display("FAIL dur[%0d]: previous output held %0d cycles, expected %0d",
                                     n_evt, held, e.dur);
                        end
                    end
                end
                prev = cur;
                held = 1;
            end else begin
                held++;
            end
            if (!rst_s) held = 1;

            if (!rst_s) begin
                tcnt = 1;
            end else begin
                tcnt++;
                if (tick || tcnt >= 4) begin
                    n_chk++;
                    if (!(tick && tcnt == 4)) begin
                        n_fail++;
                        $display("FAIL tick_period: got tick=%0b at count %0d, expected tick=1 at count 4",
                                 tick, tcnt);
                    end
                    tcnt = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if ({ciclo, dest, mode, tick} !== {5'd7, 1'b0, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got ciclo=%0d dest=%0b mode=%b tick=%0b, expected 7 0 11 0",
                     ciclo, dest, mode, tick);
        end
        rst = 1'b1;

        // 1: full rotation, nothing skipped
        ex(0,0,2'b00,4);  ex(0,1,2'b00,16); ex(1,0,2'b00,8);
        ex(2,0,2'b00,8);  ex(2,1,2'b00,16); ex(3,0,2'b00,8);
        ex(4,0,2'b00,8);  ex(4,1,2'b00,16); ex(5,0,2'b00,8);
        ex(6,0,2'b00,8);  ex(6,1,2'b00,16); ex(7,0,2'b11,8);
        ex(0,0,2'b00,4);
        wait_edges(129);
        ex(7,0,2'b11,2);
        do_reset(4'b0110);

        // 2: approaches 1 and 2 skipped
        ex(0,0,2'b00,4);  ex(0,1,2'b00,16); ex(1,0,2'b00,8);
        ex(6,0,2'b00,8);  ex(6,1,2'b00,16); ex(7,0,2'b11,8);
        ex(0,0,2'b00,4);
        wait_edges(65);
        ex(7,0,2'b11,2);
        do_reset(4'b0000);

        // 3: emergency raised during green of approach 1
        ex(0,0,2'b00,4);  ex(0,1,2'b00,16); ex(1,0,2'b00,8);
        ex(2,0,2'b00,8);  ex(3,0,2'b00,5);  ex(7,0,2'b11,7);
        ex(7,0,2'b10,4);  ex(7,0,2'b11,9);  ex(0,0,2'b00,3);
        wait_edges(40); emerg = 1'b1;
        wait_edges(20); emerg = 1'b0;
        wait_edges(5);
        ex(7,0,2'b11,2);
        do_reset(4'b0111);

        // 4: night during blinking green of approach 3, emergency during night
        ex(6,0,2'b00,4);  ex(6,1,2'b00,16); ex(7,0,2'b11,3);
        ex(8,1,2'b01,1);  ex(7,0,2'b10,7);  ex(7,0,2'b11,4);
        ex(8,1,2'b01,1);  ex(7,0,2'b11,3);  ex(6,0,2'b00,1);
        wait_edges(22); night = 1'b1;
        wait_edges(8);  emerg = 1'b1;
        wait_edges(4);  emerg = 1'b0;
        wait_edges(4);  night = 1'b0;
        wait_edges(3);
        ex(7,0,2'b11,2);
        do_reset(4'b1111);

        // 5: everything skipped, then approach 2 re-enabled
        ex(4,0,2'b00,32);
        wait_edges(30); skip = 4'b1011;
        wait_edges(3);
        ex(7,0,2'b11,2);
        do_reset(4'b0000);

        // 6: reset in the middle of yellow of approach 0
        ex(0,0,2'b00,4);  ex(0,1,2'b00,16); ex(1,0,2'b00,8);
        wait_edges(29);
        ex(7,0,2'b11,2);
        do_reset(4'b0000);
        ex(0,0,2'b00,4);
        wait_edges(8);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: %0d expected output changes never seen, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/semaforo_sequencer.md
Name: semaforo_sequencer

Overview:
- Local phase sequencer for the 4-approach intersection. It generates the 5-bit cycle code and the blink-enable consumed by the existing traffic-light decoder, which makes the ESP32 optional.
- Contains its own 1 Hz tick prescaler, per-phase timers, an approach-skip mask, and night/emergency modes with mandatory yellow and all-red clearance.
- Sits between the top-level mode inputs and the decoder. The top ANDs `dest` with its blink pulse.

Parameters:
- CLK_DIV, 27_000_000, clk cycles per tick (≥2).
- T_GREEN, 20, steady-green ticks.
- T_BLINK, 3, blinking-green ticks.
- T_YELLOW, 3, yellow ticks (approaches 0-2).
- T_ALLRED, 2, all-red clearance ticks.
- TW, 8, phase-timer width. All T_* values are in 1..2^TW-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- night  in  1  request flashing-yellow night mode (level)
- emerg  in  1  request all-red emergency hold (level, highest priority)
- skip  in  4  skip[a]=1 removes approach a from rotation
- ciclo  out  5  cycle code to decoder
- dest  out  1  blink enable to decoder
- tick  out  1  one-cycle prescaler pulse
- mode  out  2  00 normal, 01 night, 10 emergency, 11 clearing

Behaviour:
- Prescaler: counts 0..CLK_DIV-1 and wraps. `tick`=1 when count==CLK_DIV-1. It is free-running and is not cleared on state changes.
- Phase timer `rem` is loaded with the phase's T_* on entry. It decrements on each tick. A tick with rem==1 ends the phase, and the transition happens on that same clk edge.
- Outputs are a Moore decode of the state register (no extra latency). Output encoding per state:
  - GREEN(a): ciclo=2a, dest=0, mode 00.
  - GBLINK(a): ciclo=2a, dest=1, mode 00.
  - YELLOW(a), a in 0..2: ciclo=2a+1, dest=0, mode 00.
  - CLEAR: ciclo=7, dest=0, mode 11.
  - NIGHT: ciclo=8, dest=1, mode 01.
  - EMERG: ciclo=7, dest=0, mode 10.
- Reset (rst=0 at an edge): state=CLEAR, rem=T_ALLRED, prescaler=0, ciclo=7, dest=0, mode=11, tick=0. Reset mid-phase aborts immediately.
- Normal transitions:
  - GREEN(a) → GBLINK(a).
  - GBLINK(a), a<3 → YELLOW(a).
  - GBLINK(3) → CLEAR (approach 3 has no yellow code).
  - YELLOW(a) → GREEN(b), where b is the lowest unskipped approach with b>a. If none exists → CLEAR.
- CLEAR expiry, evaluated in priority order:
  - emerg → EMERG.
  - else night → NIGHT.
  - else GREEN(lowest unskipped approach).
  - else (all skipped) reload T_ALLRED and stay in CLEAR.
- Mode entry from GREEN(a)/GBLINK(a) when emerg or night is sampled high at any cycle:
  - a<3 → YELLOW(a) immediately, with full T_YELLOW.
  - a=3 → CLEAR immediately.
  - YELLOW and CLEAR always run to completion. After YELLOW, the pending request forces CLEAR regardless of skip.
- NIGHT: if emerg → EMERG immediately. If night=0 → CLEAR.
- EMERG: when emerg=0 → CLEAR. A night request is handled at CLEAR expiry.
- Timers do not run in NIGHT or EMERG.
- skip is sampled only at the transition decision. Changing skip mid-green does not shorten the green.

Decomposition:
- Package semaforo_pkg:
  - state enum (GREEN, GBLINK, YELLOW, CLEAR, NIGHT, EMERG) plus a 2-bit approach index.
  - code constants CODE_CLEAR=7, CODE_NIGHT=8.
  - mode encodings.
- Sub-module tick_prescaler (param CLK_DIV → tick).
- FSM, timer and next-approach priority logic stay in semaforo_sequencer.

Test Plan:
All scenarios use CLK_DIV=4, T_GREEN=4, T_BLINK=2, T_YELLOW=2, T_ALLRED=1.
1. Reset release, skip=0, night=emerg=0 → ciclo=7 until the first tick (cycle 3). Then the sequence is 0/d0 ×4 ticks, 0/d1 ×2, 1 ×2, 2/d0 ×4, …, 6/d1 ×2, 7 ×1, then 0 again. tick period is 4 cycles.
2. skip=4'b0110 → order is 0,1 (yellow), then 6 (approach 3 green, skipping 1 and 2), then 7, then 0. ciclo never takes values 2-5.
3. emerg pulse raised during GREEN(1), ciclo=2 → next edge gives ciclo=3 for 2 ticks, then 7 with mode=10 and held. On emerg drop → mode=11 for 1 tick, then ciclo=0.
4. night raised during GBLINK(3) → next edge gives ciclo=7/mode 11, then ciclo=8, dest=1, mode=01. emerg raised while in night → next edge gives mode=10.
5. skip=4'b1111 → ciclo stays 7 and mode stays 11 indefinitely. Clearing skip[2] → ciclo=4 at the next CLEAR expiry.
6. rst asserted mid-YELLOW(0) → next edge gives ciclo=7, mode=11, prescaler=0.
